// File: rtl/trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : trap_ctrl
// Purpose  : Trap sequencer between the IF/ID pipeline stages and the CSR
//            file. It arbitrates exception and MRET requests, then drives the
//            CSR write inputs for exactly one commit cycle. After that it
//            flushes the pipeline for a fixed drain period and issues a
//            single-cycle PC redirect to mtvec (trap) or mepc (MRET).
// Ports    : clk, rst               - clock, async active-high reset
//            if_misaligned/if_pc/if_target   - IF-stage fetch-misalign request
//            id_illegal/id_is_mret/id_pc/id_ir - ID-stage requests
//            mtvec_in, mepc_in      - CSR values used as redirect targets
//            cause_out/epc_out/tval_out/is_mret_out - CSR commit interface
//            flush, busy            - pipeline squash / sequencer active
//            redirect_valid/redirect_pc - one-cycle PC redirect
// Revision : 1.0 - initial release
// ============================================================================
module trap_ctrl #(
  parameter logic [1:0] NOT_EXCEPTION       = 2'b00,
  parameter logic [1:0] I_ADDR_MISALIGNMENT = 2'b01,
  parameter logic [1:0] ILLEGAL_IR          = 2'b10,
  parameter int         FLUSH_CYCLES        = 2      // legal range 1..7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_misaligned,
  input  logic [31:0] if_pc,
  input  logic [31:0] if_target,
  input  logic        id_illegal,
  input  logic        id_is_mret,
  input  logic [31:0] id_pc,
  input  logic [31:0] id_ir,
  input  logic [31:0] mtvec_in,
  input  logic [31:0] mepc_in,
  output logic [1:0]  cause_out,
  output logic [31:0] epc_out,
  output logic [31:0] tval_out,
  output logic        is_mret_out,
  output logic        flush,
  output logic        busy,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_COMMIT   = 2'd1;
  localparam logic [1:0] S_DRAIN    = 2'd2;
  localparam logic [1:0] S_REDIRECT = 2'd3;

  localparam logic [1:0] K_ILL  = 2'd0;
  localparam logic [1:0] K_MIS  = 2'd1;
  localparam logic [1:0] K_MRET = 2'd2;

  localparam logic [2:0] CNT_INIT = 3'(FLUSH_CYCLES - 1);

  logic [1:0]  state;
  logic [1:0]  state_nxt;
  logic [2:0]  cnt;
  logic [1:0]  kind;
  logic [31:0] epc_q;
  logic [31:0] tval_q;
  logic        req_any;

  assign req_any = id_illegal | id_is_mret | if_misaligned;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; requests only matter in IDLE, so anything arriving
  // while busy (including the REDIRECT cycle) is dropped.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:     if (req_any) state_nxt = S_COMMIT;
      S_COMMIT:   state_nxt = (FLUSH_CYCLES == 1) ? S_REDIRECT : S_DRAIN;
      S_DRAIN:    if (cnt == 3'd1) state_nxt = S_REDIRECT;
      S_REDIRECT: state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // Request latch and drain counter. The ID stage holds the older
  // instruction, so any ID request masks the IF misalignment.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= 3'd0;
      kind   <= K_ILL;
      epc_q  <= 32'd0;
      tval_q <= 32'd0;
    end else begin
      case (state)
        S_IDLE: begin
          cnt <= 3'd0;
          if (id_illegal) begin
            kind   <= K_ILL;
            epc_q  <= id_pc;
            tval_q <= id_ir;
          end else if (id_is_mret) begin
            kind   <= K_MRET;
            epc_q  <= 32'd0;
            tval_q <= 32'd0;
          end else if (if_misaligned) begin
            kind   <= K_MIS;
            epc_q  <= if_pc;
            tval_q <= if_target;
          end
        end
        S_COMMIT: cnt <= (FLUSH_CYCLES == 1) ? 3'd0 : CNT_INIT;
        S_DRAIN:  cnt <= cnt - 3'd1;
        default:  cnt <= 3'd0;
      endcase
    end
  end

  // Outputs: CSR inputs are non-zero only in COMMIT so the CSR file sees a
  // single write; redirect targets are read live so a CSR update made at the
  // COMMIT edge is already visible.
  always_comb begin
    cause_out      = NOT_EXCEPTION;
    epc_out        = 32'd0;
    tval_out       = 32'd0;
    is_mret_out    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    busy           = (state != S_IDLE);
    flush          = (state != S_IDLE);
    case (state)
      S_COMMIT: begin
        if (kind == K_MRET) begin
          is_mret_out = 1'b1;
        end else begin
          cause_out = (kind == K_ILL) ? ILLEGAL_IR : I_ADDR_MISALIGNMENT;
          epc_out   = epc_q;
          tval_out  = tval_q;
        end
      end
      S_REDIRECT: begin
        redirect_valid = 1'b1;
        redirect_pc    = (kind == K_MRET) ? {mepc_in[31:2], 2'b00}
                                          : {mtvec_in[31:2], 2'b00};
      end
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_trap_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_trap_ctrl
// Purpose  : Directed self-checking bench for trap_ctrl. A default instance
//            (FLUSH_CYCLES=2) and a FLUSH_CYCLES=1 instance share inputs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        if_misaligned = 1'b0;
  logic [31:0] if_pc = '0;
  logic [31:0] if_target = '0;
  logic        id_illegal = 1'b0;
  logic        id_is_mret = 1'b0;
  logic [31:0] id_pc = '0;
  logic [31:0] id_ir = '0;
  logic [31:0] mtvec_in = '0;
  logic [31:0] mepc_in = '0;

  logic [1:0]  cause_out;
  logic [31:0] epc_out, tval_out, redirect_pc;
  logic        is_mret_out, flush, busy, redirect_valid;

  logic [1:0]  cause1;
  logic [31:0] epc1, tval1, redirect_pc1;
  logic        is_mret1, flush1, busy1, redirect_valid1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  trap_ctrl u_dut (
    .clk(clk), .rst(rst),
    .if_misaligned(if_misaligned), .if_pc(if_pc), .if_target(if_target),
    .id_illegal(id_illegal), .id_is_mret(id_is_mret), .id_pc(id_pc), .id_ir(id_ir),
    .mtvec_in(mtvec_in), .mepc_in(mepc_in),
    .cause_out(cause_out), .epc_out(epc_out), .tval_out(tval_out),
    .is_mret_out(is_mret_out), .flush(flush), .busy(busy),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  trap_ctrl #(.FLUSH_CYCLES(1)) u_one (
    .clk(clk), .rst(rst),
    .if_misaligned(if_misaligned), .if_pc(if_pc), .if_target(if_target),
    .id_illegal(id_illegal), .id_is_mret(id_is_mret), .id_pc(id_pc), .id_ir(id_ir),
    .mtvec_in(mtvec_in), .mepc_in(mepc_in),
    .cause_out(cause1), .epc_out(epc1), .tval_out(tval1),
    .is_mret_out(is_mret1), .flush(flush1), .busy(busy1),
    .redirect_valid(redirect_valid1), .redirect_pc(redirect_pc1)
  );

  task automatic clear_req;
    if_misaligned = 1'b0;
    id_illegal    = 1'b0;
    id_is_mret    = 1'b0;
  endtask

  // Let both instances settle back to IDLE between scenarios.
  task automatic idle_gap;
    clear_req();
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset;
    @(negedge clk);
    checks++;
    if ({cause_out, epc_out, tval_out, is_mret_out, flush, busy, redirect_valid, redirect_pc} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got cause=%h epc=%h tval=%h mret=%b flush=%b busy=%b rv=%b rpc=%h want all 0",
               cause_out, epc_out, tval_out, is_mret_out, flush, busy, redirect_valid, redirect_pc);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || busy1 !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_idle got busy=%b busy1=%b want 0 0", busy, busy1);
    end
  endtask

  task automatic test_illegal;
    @(negedge clk);
    id_illegal = 1'b1; id_pc = 32'h0001_0040; id_ir = 32'hFFFF_FFFF; mtvec_in = 32'h0000_0100;
    @(negedge clk);   // COMMIT
    clear_req();
    checks++;
    if (cause_out !== 2'b10 || epc_out !== 32'h0001_0040 || tval_out !== 32'hFFFF_FFFF ||
        is_mret_out !== 1'b0 || flush !== 1'b1 || redirect_valid !== 1'b0) begin
      errors++;
      $display("FAIL ill_commit got cause=%h epc=%h tval=%h mret=%b flush=%b rv=%b want 2 00010040 ffffffff 0 1 0",
               cause_out, epc_out, tval_out, is_mret_out, flush, redirect_valid);
    end
    @(negedge clk);   // DRAIN
    checks++;
    if (cause_out !== 2'b00 || epc_out !== 32'h0 || tval_out !== 32'h0 || flush !== 1'b1 ||
        busy !== 1'b1 || redirect_valid !== 1'b0 || redirect_pc !== 32'h0) begin
      errors++;
      $display("FAIL ill_drain got cause=%h epc=%h tval=%h flush=%b busy=%b rv=%b rpc=%h want 0 0 0 1 1 0 0",
               cause_out, epc_out, tval_out, flush, busy, redirect_valid, redirect_pc);
    end
    @(negedge clk);   // REDIRECT
    checks++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h0000_0100 || flush !== 1'b1 || cause_out !== 2'b00) begin
      errors++;
      $display("FAIL ill_redirect got rv=%b rpc=%h flush=%b cause=%h want 1 00000100 1 0",
               redirect_valid, redirect_pc, flush, cause_out);
    end
    @(negedge clk);   // IDLE
    checks++;
    if (busy !== 1'b0 || flush !== 1'b0 || redirect_valid !== 1'b0) begin
      errors++;
      $display("FAIL ill_idle got busy=%b flush=%b rv=%b want 0 0 0", busy, flush, redirect_valid);
    end
  endtask

  task automatic test_misaligned;
    idle_gap();
    if_misaligned = 1'b1; if_pc = 32'h0001_0008; if_target = 32'h0001_0022; mtvec_in = 32'h0000_0202;
    @(negedge clk);   // COMMIT
    clear_req();
    checks++;
    if (cause_out !== 2'b01 || epc_out !== 32'h0001_0008 || tval_out !== 32'h0001_0022 || is_mret_out !== 1'b0) begin
      errors++;
      $display("FAIL mis_commit got cause=%h epc=%h tval=%h mret=%b want 1 00010008 00010022 0",
               cause_out, epc_out, tval_out, is_mret_out);
    end
    repeat (2) @(negedge clk);   // REDIRECT
    checks++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h0000_0200) begin
      errors++;
      $display("FAIL mis_redirect got rv=%b rpc=%h want 1 00000200", redirect_valid, redirect_pc);
    end
  endtask

  task automatic test_mret;
    idle_gap();
    id_is_mret = 1'b1; mepc_in = 32'h0001_0044;
    @(negedge clk);   // COMMIT
    clear_req();
    checks++;
    if (is_mret_out !== 1'b1 || cause_out !== 2'b00 || epc_out !== 32'h0 || tval_out !== 32'h0) begin
      errors++;
      $display("FAIL mret_commit got mret=%b cause=%h epc=%h tval=%h want 1 0 0 0",
               is_mret_out, cause_out, epc_out, tval_out);
    end
    @(negedge clk);   // DRAIN
    checks++;
    if (is_mret_out !== 1'b0) begin
      errors++;
      $display("FAIL mret_single_pulse got mret=%b want 0", is_mret_out);
    end
    @(negedge clk);   // REDIRECT
    checks++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h0001_0044) begin
      errors++;
      $display("FAIL mret_redirect got rv=%b rpc=%h want 1 00010044", redirect_valid, redirect_pc);
    end
    // mepc changes after COMMIT; the redirect must use the live, aligned value.
    idle_gap();
    id_is_mret = 1'b1; mepc_in = 32'h0000_0000;
    @(negedge clk);   // COMMIT
    clear_req();
    @(negedge clk);   // DRAIN
    mepc_in = 32'h0001_0047;
    @(negedge clk);   // REDIRECT
    checks++;
    if (redirect_valid !== 1'b1 || redirect_pc !== 32'h0001_0044) begin
      errors++;
      $display("FAIL mret_live_align got rv=%b rpc=%h want 1 00010044", redirect_valid, redirect_pc);
    end
  endtask

  task automatic test_simultaneous;
    idle_gap();
    id_illegal = 1'b1; id_is_mret = 1'b1; if_misaligned = 1'b1;
    id_pc = 32'h0000_2000; id_ir = 32'h0000_1234; if_pc = 32'h0000_3000; if_target = 32'h0000_3002;
    mtvec_in = 32'h0000_0400; mepc_in = 32'h0000_0800;
    @(negedge clk);   // COMMIT
    clear_req();
    checks++;
    if (cause_out !== 2'b10 || epc_out !== 32'h0000_2000 || tval_out !== 32'h0000_1234 || is_mret_out !== 1'b0) begin
      errors++;
      $display("FAIL all3_commit got cause=%h epc=%h tval=%h mret=%b want 2 00002000 00001234 0",
               cause_out, epc_out, tval_out, is_mret_out);
    end
    @(negedge clk);   // DRAIN
    checks++;
    if (cause_out !== 2'b00 || is_mret_out !== 1'b0) begin
      errors++;
      $display("FAIL all3_single_pulse got cause=%h mret=%b want 0 0", cause_out, is_mret_out);
    end
    @(negedge clk);   // REDIRECT
    checks++;
    if (redirect_pc !== 32'h0000_0400) begin
      errors++;
      $display("FAIL all3_redirect got rpc=%h want 00000400", redirect_pc);
    end
    idle_gap();
    id_is_mret = 1'b1; if_misaligned = 1'b1;
    @(negedge clk);   // COMMIT
    clear_req();
    checks++;
    if (is_mret_out !== 1'b1 || cause_out !== 2'b00 || epc_out !== 32'h0) begin
      errors++;
      $display("FAIL mret_mis_commit got mret=%b cause=%h epc=%h want 1 0 0", is_mret_out, cause_out, epc_out);
    end
    repeat (2) @(negedge clk);   // REDIRECT
    checks++;
    if (redirect_pc !== 32'h0000_0800) begin
      errors++;
      $display("FAIL mret_mis_redirect got rpc=%h want 00000800", redirect_pc);
    end
  endtask

  task automatic test_busy_ignore;
    idle_gap();
    id_illegal = 1'b1; id_pc = 32'h0000_5000; id_ir = 32'h0000_0BAD; mtvec_in = 32'h0000_0100;
    @(negedge clk);   // COMMIT
    clear_req();
    @(negedge clk);   // DRAIN
    id_illegal = 1'b1; id_pc = 32'h0000_6000;
    checks++;
    if (cause_out !== 2'b00) begin
      errors++;
      $display("FAIL busy_drain_cause got cause=%h want 0", cause_out);
    end
    @(negedge clk);   // REDIRECT, request still asserted
    checks++;
    if (redirect_valid !== 1'b1 || cause_out !== 2'b00) begin
      errors++;
      $display("FAIL busy_redirect got rv=%b cause=%h want 1 0", redirect_valid, cause_out);
    end
    @(negedge clk);   // IDLE, 4 cycles after first sample
    clear_req();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_drop got busy=%b want 0", busy);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || cause_out !== 2'b00) begin
      errors++;
      $display("FAIL busy_no_second_commit got busy=%b cause=%h want 0 0", busy, cause_out);
    end
  endtask

  task automatic test_reset_mid;
    int rv_seen;
    idle_gap();
    id_illegal = 1'b1; id_pc = 32'h0000_7000; id_ir = 32'h0000_0001;
    @(negedge clk);   // COMMIT
    clear_req();
    @(negedge clk);   // DRAIN
    rst = 1'b1;
    #1;
    checks++;
    if ({cause_out, epc_out, tval_out, is_mret_out, flush, busy, redirect_valid, redirect_pc} !== '0) begin
      errors++;
      $display("FAIL reset_mid_async got flush=%b busy=%b rv=%b cause=%h want 0 0 0 0",
               flush, busy, redirect_valid, cause_out);
    end
    @(negedge clk);
    rst = 1'b0;
    rv_seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (redirect_valid !== 1'b0) rv_seen++;
    end
    checks++;
    if (rv_seen != 0) begin
      errors++;
      $display("FAIL reset_mid_no_redirect got %0d redirect cycles want 0", rv_seen);
    end
    id_illegal = 1'b1; id_pc = 32'h0000_7100; id_ir = 32'h0000_0002;
    @(negedge clk);   // COMMIT
    clear_req();
    checks++;
    if (cause_out !== 2'b10 || epc_out !== 32'h0000_7100) begin
      errors++;
      $display("FAIL reset_mid_next_req got cause=%h epc=%h want 2 00007100", cause_out, epc_out);
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_flush_one;
    idle_gap();
    id_illegal = 1'b1; id_pc = 32'h0000_8000; id_ir = 32'h0000_0003; mtvec_in = 32'h0000_0C00;
    @(negedge clk);   // COMMIT for both
    clear_req();
    checks++;
    if (cause1 !== 2'b10 || epc1 !== 32'h0000_8000 || tval1 !== 32'h0000_0003 || flush1 !== 1'b1) begin
      errors++;
      $display("FAIL one_commit got cause=%h epc=%h tval=%h flush=%b want 2 00008000 00000003 1",
               cause1, epc1, tval1, flush1);
    end
    @(negedge clk);   // REDIRECT on u_one, DRAIN on u_dut
    checks++;
    if (redirect_valid1 !== 1'b1 || redirect_pc1 !== 32'h0000_0C00 || redirect_valid !== 1'b0) begin
      errors++;
      $display("FAIL one_redirect got rv1=%b rpc1=%h rv=%b want 1 00000c00 0",
               redirect_valid1, redirect_pc1, redirect_valid);
    end
    @(negedge clk);
    checks++;
    if (busy1 !== 1'b0 || redirect_valid !== 1'b1) begin
      errors++;
      $display("FAIL one_idle got busy1=%b rv=%b want 0 1", busy1, redirect_valid);
    end
  endtask

  initial begin
    test_reset();
    test_illegal();
    test_misaligned();
    test_mret();
    test_simultaneous();
    test_busy_ignore();
    test_reset_mid();
    test_flush_one();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/trap_ctrl.md
Name: trap_ctrl

Overview:
- Trap sequencer sitting between the pipeline stages (IF/ID) and the CSR file.
- Arbitrates exception and MRET requests, then drives the CSR file's cause/epc/tval/is_mret inputs for exactly one commit cycle.
- Flushes the pipeline for a fixed drain period, then issues a single-cycle PC redirect to mtvec (trap) or mepc (MRET).

Parameters:
- NOT_EXCEPTION, 2'b00, cause code meaning "no exception".
- I_ADDR_MISALIGNMENT, 2'b01, cause code for a misaligned fetch target.
- ILLEGAL_IR, 2'b10, cause code for an illegal instruction.
- FLUSH_CYCLES, 2, number of cycles flush is held before redirect (legal range 1..7).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- if_misaligned  input  1  IF stage reports a misaligned fetch target.
- if_pc  input  32  PC of the IF-stage instruction.
- if_target  input  32  misaligned target address.
- id_illegal  input  1  ID stage reports an illegal instruction.
- id_is_mret  input  1  ID stage holds a valid MRET.
- id_pc  input  32  PC of the ID-stage instruction.
- id_ir  input  32  instruction word in ID.
- mtvec_in  input  32  mtvec value from the CSR file.
- mepc_in  input  32  mepc value from the CSR file.
- cause_out  output  2  cause code to the CSR file.
- epc_out  output  32  exception PC to the CSR file.
- tval_out  output  32  trap value to the CSR file.
- is_mret_out  output  1  MRET commit strobe to the CSR file.
- flush  output  1  squash all IF/ID/EX contents.
- busy  output  1  high whenever state is not IDLE.
- redirect_valid  output  1  one-cycle PC redirect strobe.
- redirect_pc  output  32  redirect target.

Behaviour:
- States: IDLE, COMMIT, DRAIN, REDIRECT. A 3-bit drain counter holds the DRAIN count.
- Reset: asynchronous. Forces IDLE and counter=0. All outputs 0, with cause_out=NOT_EXCEPTION. rst asserted mid-sequence aborts it immediately; no redirect is issued.
- IDLE arbitration, sampled each rising edge:
  - id_illegal has highest priority.
  - id_is_mret is next. If id_illegal and id_is_mret are both set, it is treated as illegal.
  - if_misaligned is lowest priority. It is dropped whenever any ID request is present, because the older instruction wins.
  - The winner is latched as kind (TRAP_ILL, TRAP_MIS, MRET) together with its epc/tval:
    - illegal: epc=id_pc, tval=id_ir.
    - misaligned: epc=if_pc, tval=if_target.
    - MRET: epc and tval are don't-care and drive 0.
  - Any request moves IDLE to COMMIT. No request keeps the block in IDLE.
- COMMIT (exactly 1 cycle):
  - Trap: cause_out = latched code, epc_out/tval_out = latched values, is_mret_out=0.
  - MRET: cause_out=NOT_EXCEPTION, is_mret_out=1.
  - flush=1.
  - Next state is DRAIN with counter=FLUSH_CYCLES-1, or REDIRECT directly if FLUSH_CYCLES==1.
- Outside COMMIT, cause_out=NOT_EXCEPTION, is_mret_out=0, and epc_out/tval_out=0. This guarantees the CSR file sees exactly one write.
- DRAIN: flush=1. Counter decrements each cycle; the block moves to REDIRECT on the cycle the counter is 1.
- REDIRECT (1 cycle):
  - flush=1, redirect_valid=1.
  - redirect_pc = {mtvec_in[31:2],2'b00} for a trap, or {mepc_in[31:2],2'b00} for MRET.
  - Both values are sampled combinationally in this cycle, so mepc reflects any CSR write that completed at the COMMIT edge.
  - Next state is IDLE.
- Outside REDIRECT, redirect_valid=0 and redirect_pc=0.
- All requests are ignored while busy, including requests arriving in the REDIRECT cycle. Squashed instructions cannot trap.
- A request may be accepted on the first IDLE cycle after REDIRECT, giving back-to-back traps.
- Latency with default parameters: a request sampled at edge N gives COMMIT in cycle N+1, DRAIN in N+2, REDIRECT in N+3, and IDLE in N+4.
- busy = (state != IDLE). flush = busy.

Test Plan:
- Illegal instruction: id_illegal=1, id_pc=0x0001_0040, id_ir=0xFFFF_FFFF, mtvec_in=0x0000_0100.
  - Next cycle: cause_out=2'b10, epc_out=0x0001_0040, tval_out=0xFFFF_FFFF.
  - flush high for 3 cycles.
  - Redirect cycle: redirect_valid=1, redirect_pc=0x0000_0100.
- Misaligned fetch: if_misaligned=1, if_pc=0x0001_0008, if_target=0x0001_0022.
  - COMMIT: cause_out=2'b01, epc_out=0x0001_0008, tval_out=0x0001_0022.
  - Redirect to mtvec.
- MRET: id_is_mret=1, mepc_in=0x0001_0044.
  - COMMIT: is_mret_out=1, cause_out=2'b00.
  - REDIRECT: redirect_pc=0x0001_0044.
  - mepc_in=0x0001_0047 gives redirect_pc=0x0001_0044.
- Simultaneous requests:
  - id_illegal + id_is_mret + if_misaligned together: only cause 2'b10 with id_pc, a single commit pulse.
  - id_is_mret + if_misaligned: MRET only.
- Requests while busy: assert id_illegal during DRAIN and REDIRECT. No second COMMIT occurs; busy drops 4 cycles after the first sample.
- Reset and parameters:
  - rst pulsed during DRAIN: all outputs 0 immediately, redirect_valid never asserts, the next request is accepted normally.
  - FLUSH_CYCLES=1: REDIRECT follows COMMIT directly.
